// File: rtl/filter_pkg.sv
// Shared constants for the 3x3 filter front-end: FSM encoding, filter slave
// register map and the packed RGB pixel width.
package filter_pkg;

    localparam int unsigned RGB_WIDTH = 24;

    // Sequencer FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    // Filter slave register map: nine pixel registers, result read at 0
    localparam logic [3:0] PIXEL_0_ADDR = 4'd0;
    localparam logic [3:0] PIXEL_1_ADDR = 4'd1;
    localparam logic [3:0] PIXEL_2_ADDR = 4'd2;
    localparam logic [3:0] PIXEL_3_ADDR = 4'd3;
    localparam logic [3:0] PIXEL_4_ADDR = 4'd4;
    localparam logic [3:0] PIXEL_5_ADDR = 4'd5;
    localparam logic [3:0] PIXEL_6_ADDR = 4'd6;
    localparam logic [3:0] PIXEL_7_ADDR = 4'd7;
    localparam logic [3:0] PIXEL_8_ADDR = 4'd8;
    localparam logic [3:0] RESULT_ADDR  = 4'd0;

    // Index of the final write beat of a window
    localparam logic [3:0] LAST_BEAT = 4'd8;

    // Map a write beat (window pixel index) onto its slave register address
    function automatic logic [3:0] pixel_addr(input logic [3:0] beat);
        logic [3:0] addr;
        case (beat)
            4'd0:    addr = PIXEL_0_ADDR;
            4'd1:    addr = PIXEL_1_ADDR;
            4'd2:    addr = PIXEL_2_ADDR;
            4'd3:    addr = PIXEL_3_ADDR;
            4'd4:    addr = PIXEL_4_ADDR;
            4'd5:    addr = PIXEL_5_ADDR;
            4'd6:    addr = PIXEL_6_ADDR;
            4'd7:    addr = PIXEL_7_ADDR;
            4'd8:    addr = PIXEL_8_ADDR;
            default: addr = PIXEL_0_ADDR;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: combinational read, synchronous write at the
// same column address. Contents are deliberately not reset.
module line_buffer
    import filter_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = RGB_WIDTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming row pixel; the old value is still visible on rd_data this cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[addr];

endmodule

// File: rtl/filter_window_sequencer.sv
// Streaming front-end for the 3x3 filter slave: builds 3x3 windows from a
// raster RGB stream using two line buffers, writes each complete window to
// the filter over Avalon-MM, reads back the 8-bit result and streams it out.
module filter_window_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned IMG_WIDTH     = 64,
    parameter int unsigned IMG_HEIGHT    = 48,
    parameter int unsigned BIT_PER_PIXEL = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3*BIT_PER_PIXEL-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 m_address,
    output logic                       m_write,
    output logic [31:0]                m_writedata,
    output logic                       m_read,
    input  logic [31:0]                m_readdata,
    input  logic                       m_waitrequest,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int unsigned PIX_W = 3 * BIT_PER_PIXEL;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);

    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN_MIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_WIN_MIN = ROW_W'(2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    // Window storage, pixel index = row*3 + column (0 = top-left, 8 = bottom-right)
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];

    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [3:0]       beat_q, beat_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             last_win_q, last_win_d;

    logic             m_write_q, m_write_d;
    logic             m_read_q, m_read_d;
    logic [3:0]       m_address_q, m_address_d;
    logic [31:0]      m_writedata_q, m_writedata_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [7:0]       out_data_q, out_data_d;

    logic             accept_s;
    logic [PIX_W-1:0] lb0_rd_s;
    logic [PIX_W-1:0] lb1_rd_s;
    logic             unused_readdata_s;

    // Only the result byte of the read data carries information
    assign unused_readdata_s = ^m_readdata[31:8];

    assign in_ready = reset_n & (state_q == ST_IDLE);
    assign accept_s = in_valid & in_ready;

    // lb0 holds the previous row, lb1 the row before it
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (col_q),
        .wr_data (in_data),
        .rd_data (lb0_rd_s)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (col_q),
        .wr_data (lb0_rd_s),
        .rd_data (lb1_rd_s)
    );

    // Next-state logic: raster position, window shift and bus/stream strobes
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        beat_d        = beat_q;
        settle_d      = settle_q;
        last_win_d    = last_win_q;
        win_d         = win_q;
        m_write_d     = m_write_q;
        m_read_d      = m_read_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_data_d    = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Shift window left; the new right column is {top, mid, bot}
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*3 + 0] = win_q[r*3 + 1];
                        win_d[r*3 + 1] = win_q[r*3 + 2];
                    end
                    win_d[2] = lb1_rd_s;
                    win_d[5] = lb0_rd_s;
                    win_d[8] = in_data;

                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d = {ROW_W{1'b0}};
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end

                    // A full 3x3 neighbourhood exists once two rows and two columns precede
                    if ((row_q >= ROW_WIN_MIN) && (col_q >= COL_WIN_MIN)) begin
                        state_d       = ST_WRITE;
                        beat_d        = 4'd0;
                        last_win_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
                        m_write_d     = 1'b1;
                        m_address_d   = pixel_addr(4'd0);
                        m_writedata_d = {{(32-PIX_W){1'b0}}, win_d[0]};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (!m_waitrequest) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d       = ST_SETTLE;
                        settle_d      = {SET_W{1'b0}};
                        m_write_d     = 1'b0;
                        m_address_d   = 4'd0;
                        m_writedata_d = 32'd0;
                    end else begin
                        beat_d        = beat_q + 4'd1;
                        m_address_d   = pixel_addr(beat_d);
                        m_writedata_d = {{(32-PIX_W){1'b0}}, win_q[beat_d]};
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_SETTLE: begin
                // Idle gap lets the slave's registered waitrequest rise before the read
                if (settle_q == SETTLE_LAST) begin
                    state_d     = ST_READ;
                    m_read_d    = 1'b1;
                    m_address_d = RESULT_ADDR;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            ST_READ: begin
                if (!m_waitrequest) begin
                    state_d     = ST_OUTPUT;
                    m_read_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = m_readdata[7:0];
                    out_last_d  = last_win_q;
                end else begin
                    state_d = ST_READ;
                end
            end

            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                m_write_d     = 1'b0;
                m_read_d      = 1'b0;
                m_address_d   = 4'd0;
                m_writedata_d = 32'd0;
                out_valid_d   = 1'b0;
                out_last_d    = 1'b0;
            end
        endcase
    end

    // State, counters, window and registered outputs; reset abandons any transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            row_q         <= {ROW_W{1'b0}};
            col_q         <= {COL_W{1'b0}};
            beat_q        <= 4'd0;
            settle_q      <= {SET_W{1'b0}};
            last_win_q    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= {PIX_W{1'b0}};
            end
            m_write_q     <= 1'b0;
            m_read_q      <= 1'b0;
            m_address_q   <= 4'd0;
            m_writedata_q <= 32'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            beat_q        <= beat_d;
            settle_q      <= settle_d;
            last_win_q    <= last_win_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
            m_write_q     <= m_write_d;
            m_read_q      <= m_read_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
        end
    end

    assign m_write     = m_write_q;
    assign m_read      = m_read_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_filter_window_sequencer.sv
// Bench for filter_window_sequencer on a 4x4 frame: a filter-slave model
// that stores the written pixels and returns the red byte of pixel 4, an
// image-level reference model, and a per-cycle compare process.
module tb_filter_window_sequencer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int S = 2;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         frame;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    filter_window_sequencer #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .BIT_PER_PIXEL (8),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-side variables (written only by the stimulus process)
    int cur_f, cur_r, cur_c;
    int cfg_wr_stall, cfg_rd_stall, cfg_out_block, cfg_gen;
    int n_timeouts;
    bit done;

    // Checker-side variables (written only by the compare process)
    int  n_checks = 0;
    int  n_fail = 0;
    wr_t  exp_wr[$];
    out_t exp_out[$];
    logic [23:0] img [0:H-1][0:W-1];
    logic [23:0] slv [0:8];
    bit  model_busy;
    int  seen_gen = 0;
    int  wr_stall_left = 0, rd_stall_left = 0, out_block_left = 0;
    int  wr_stall_seen = 0, rd_stall_seen = 0, out_block_seen = 0;
    int  accept_cyc = 0, last_wr_cyc = 0, rd_done_cyc = 0;
    bit  prev_wr_stall, prev_rd_stall, prev_read, prev_ov, prev_or;
    logic [3:0]  prev_addr;
    logic [31:0] prev_data;
    logic [7:0]  prev_od;
    logic        prev_ol;
    int  out_cnt [0:3] = '{0, 0, 0, 0};
    logic [7:0] f0_data [0:3];
    logic       f0_last [0:3];
    int  f0_n = 0;
    logic [7:0] fw_red [0:8];
    logic [3:0] fw_addr [0:8];
    int  fw_n = 0;
    logic [7:0] fw_exp_red [0:8] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    logic [7:0] f0_exp_data [0:3] = '{8'h11, 8'h12, 8'h21, 8'h22};
    logic       f0_exp_last [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};

    function automatic logic [23:0] pix(input int f, input int r, input int c);
        logic [7:0] b, g, rd;
        b  = 8'(128 + c);
        g  = 8'(f);
        rd = 8'(r * 16 + c);
        return {b, g, rd};
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Compare process: drives the slave/sink, follows the image model and checks every cycle
    initial begin
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            if (!reset_n) begin
                check("rst_m_write", m_write, 0);
                check("rst_m_read", m_read, 0);
                check("rst_m_address", m_address, 0);
                check("rst_m_writedata", m_writedata, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_out_last", out_last, 0);
                check("rst_out_data", out_data, 0);
                check("rst_in_ready", in_ready, 0);
                m_waitrequest = 1'b0;
                m_readdata    = 32'd0;
                out_ready     = 1'b1;
                exp_wr.delete();
                exp_out.delete();
                model_busy    = 1'b0;
                prev_wr_stall = 1'b0;
                prev_rd_stall = 1'b0;
                prev_read     = 1'b0;
                prev_ov       = 1'b0;
                prev_or       = 1'b1;
            end else if (done) begin
                check("exp_wr_left", exp_wr.size(), 0);
                check("exp_out_left", exp_out.size(), 0);
                check("frame0_results", out_cnt[0], 4);
                check("frame1_results", out_cnt[1], 4);
                check("frame2_results", out_cnt[2], 0);
                check("frame3_results", out_cnt[3], 4);
                check("stim_timeouts", n_timeouts, 0);
                check("wr_stall_cycles", wr_stall_seen, 3);
                check("rd_stall_cycles", rd_stall_seen, 20);
                check("out_block_cycles", out_block_seen, 10);
                check("first_win_writes", fw_n, 9);
                for (int i = 0; i < 9; i++) begin
                    check($sformatf("first_win_addr%0d", i), fw_addr[i], i);
                    check($sformatf("first_win_red%0d", i), fw_red[i], fw_exp_red[i]);
                end
                check("frame0_count_lit", f0_n, 4);
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("frame0_data%0d", i), f0_data[i], f0_exp_data[i]);
                    check($sformatf("frame0_last%0d", i), f0_last[i], f0_exp_last[i]);
                end
                summary();
                $finish;
            end else begin
                bit wr;
                if (cyc > 20000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL global_timeout: cycle %0d exceeded limit 20000", cyc);
                    summary();
                    $fatal(1, "bench timeout");
                end
                if (cfg_gen != seen_gen) begin
                    seen_gen       = cfg_gen;
                    wr_stall_left  = cfg_wr_stall;
                    rd_stall_left  = cfg_rd_stall;
                    out_block_left = cfg_out_block;
                end
                // Slave and sink responses for this cycle
                wr = 1'b0;
                if (m_write && m_address == 4'd4 && wr_stall_left > 0) begin
                    wr = 1'b1;
                    wr_stall_left--;
                    wr_stall_seen++;
                end else if (m_read && rd_stall_left > 0) begin
                    wr = 1'b1;
                    rd_stall_left--;
                    rd_stall_seen++;
                end
                m_waitrequest = wr;
                m_readdata    = wr ? 32'hEEEE_EEEE : {24'hA5A5A5, slv[4][7:0]};
                if (out_valid && out_block_left > 0) begin
                    out_ready = 1'b0;
                    out_block_left--;
                    out_block_seen++;
                end else begin
                    out_ready = 1'b1;
                end

                check("in_ready", in_ready, model_busy ? 0 : 1);

                // Write channel
                if (prev_wr_stall) begin
                    check("wr_hold_strobe", m_write, 1);
                    check("wr_hold_addr", m_address, prev_addr);
                    check("wr_hold_data", m_writedata, prev_data);
                end
                if (m_write && !wr) begin
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, expected no write", m_address, m_writedata);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("wr_addr", m_address, e.addr);
                        check("wr_data", m_writedata, e.data);
                        if (m_address <= 4'd8) slv[m_address] = m_writedata[23:0];
                        if (m_address == 4'd0) check("wr_start_cyc", cyc, accept_cyc + 1);
                        if (m_address == 4'd8) last_wr_cyc = cyc;
                        if (fw_n < 9) begin
                            fw_addr[fw_n] = m_address;
                            fw_red[fw_n]  = m_writedata[7:0];
                            fw_n++;
                        end
                    end
                end
                prev_wr_stall = m_write && wr;
                prev_addr     = m_address;
                prev_data     = m_writedata;

                // Read channel
                if (prev_rd_stall) begin
                    check("rd_hold_strobe", m_read, 1);
                    check("rd_hold_addr", m_address, 0);
                end
                if (m_read && !prev_read) begin
                    check("rd_start_cyc", cyc, last_wr_cyc + 1 + S);
                    check("rd_addr", m_address, 0);
                end
                if (m_read && !wr) rd_done_cyc = cyc;
                prev_rd_stall = m_read && wr;
                prev_read     = m_read;

                // Output stream
                if (out_valid && !prev_ov) check("ov_start_cyc", cyc, rd_done_cyc + 1);
                if (prev_ov && !prev_or) begin
                    check("ov_hold", out_valid, 1);
                    check("od_hold", out_data, prev_od);
                    check("ol_hold", out_last, prev_ol);
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: got result 0x%0h, expected no result", out_data);
                    end else begin
                        out_t o;
                        o = exp_out.pop_front();
                        check("out_data", out_data, o.data);
                        check("out_last", out_last, o.last);
                        out_cnt[o.frame]++;
                        if (o.frame == 0 && f0_n < 4) begin
                            f0_data[f0_n] = out_data;
                            f0_last[f0_n] = out_last;
                            f0_n++;
                        end
                    end
                    model_busy = 1'b0;
                end
                prev_ov = out_valid;
                prev_or = out_ready;
                prev_od = out_data;
                prev_ol = out_last;

                // Input acceptance feeds the image model
                if (in_valid && in_ready) begin
                    img[cur_r][cur_c] = in_data;
                    if (cur_r >= 2 && cur_c >= 2) begin
                        out_t o;
                        model_busy = 1'b1;
                        accept_cyc = cyc;
                        for (int i = 0; i < 9; i++) begin
                            wr_t e;
                            e.addr = 4'(i);
                            e.data = {8'h00, img[cur_r - 2 + i / 3][cur_c - 2 + i % 3]};
                            exp_wr.push_back(e);
                        end
                        o.data  = img[cur_r - 1][cur_c - 1][7:0];
                        o.last  = (cur_r == H - 1) && (cur_c == W - 1);
                        o.frame = cur_f;
                        exp_out.push_back(o);
                    end
                end
            end
        end
    end

    // Present one pixel and hold it until the sequencer takes it
    task automatic send_pixel(input int f, input int r, input int c);
        bit got;
        cur_f    = f;
        cur_r    = r;
        cur_c    = c;
        in_data  = pix(f, r, c);
        in_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) n_timeouts++;
    endtask

    task automatic send_frame(input int f);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(f, r, c);
            end
        end
        in_valid = 1'b0;
    endtask

    // Stimulus: clean frame, stalled frame, reset mid-window, fresh frame
    initial begin
        bit got;
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        in_data       = 24'd0;
        cur_f         = 0;
        cur_r         = 0;
        cur_c         = 0;
        cfg_wr_stall  = 0;
        cfg_rd_stall  = 0;
        cfg_out_block = 0;
        cfg_gen       = 0;
        n_timeouts    = 0;
        done          = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(0);
        repeat (40) @(posedge clk);
        #1;

        cfg_wr_stall  = 3;
        cfg_rd_stall  = 20;
        cfg_out_block = 10;
        cfg_gen       = 1;
        send_frame(1);
        repeat (80) @(posedge clk);
        #1;

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 2 || c <= 2) send_pixel(2, r, c);
            end
        end
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            if (m_write && m_address == 4'd5) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) n_timeouts++;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(3);
        repeat (40) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
